// File: rtl/cdc_pkg.sv
// Shared definitions for the slow-to-fast CDC launcher slice.
//   tx_state_e : scheduler state encoding (idle, launch pulse, hold gap).
//   CdcDw      : default CDC word width.
//   level_w()  : width of a 0..depth occupancy count.
package cdc_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSend = 2'd1,
    StGap  = 2'd2
  } tx_state_e;

  localparam int unsigned CdcDw = 4;

  function automatic int unsigned level_w(int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/cdc_s2f_tx_sched_if.sv
// Valid/ready word stream feeding the launcher.
//   s_valid : producer has a word on s_data.
//   s_data  : DW-bit word.
//   s_ready : consumer accepts the word on this edge when s_valid is high.
// master = producer side, slave = launcher side.
interface cdc_s2f_tx_sched_if
  import cdc_pkg::*;
#(
  parameter int unsigned DW = CdcDw
);

  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/cdc_sync_fifo.sv
// Single-clock DW x DEPTH FIFO with synchronous flush.
//   clk_a, arstn : clock and asynchronous active-low reset.
//   flush        : clears pointers and level; blocks push and pop that edge.
//   push, wdata  : write wdata when not full.
//   pop          : drop head when not empty.
//   rdata        : current head word (valid when !empty).
//   full, empty  : registered-state status.
//   level        : words stored, 0..DEPTH.
module cdc_sync_fifo
  import cdc_pkg::*;
#(
  parameter int unsigned DW    = CdcDw,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned LW   = AW + 1
) (
  input  logic          clk_a,
  input  logic          arstn,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rdata   = mem_q[rd_ptr_q];

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // DEPTH is a power of two, so pointer wrap is the natural AW-bit overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_a or negedge arstn) begin
    if (!arstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: nothing reads an entry before it is written.
  always_ff @(posedge clk_a) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/cdc_s2f_tx_sched.sv
// Slow-domain launcher for the multibit slow-to-fast CDC stage.
// Buffers a valid/ready word stream and launches one word at a time: data_en
// pulses for one cycle with the new word on data_out, then data_out is held and
// data_en stays low for HOLD cycles so the fast-side enable synchroniser always
// samples a static bus.
//   clk_a, arstn : slow clock, asynchronous active-low reset.
//   flush        : synchronous FIFO clear; an in-flight word still completes.
//   s            : upstream word stream (slave side).
//   data_out     : registered word to the CDC stage.
//   data_en      : registered one-cycle launch strobe.
//   fifo_level   : words queued, in-flight word excluded.
//   busy         : not idle or words queued.
module cdc_s2f_tx_sched
  import cdc_pkg::*;
#(
  parameter int unsigned DW    = CdcDw,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned HOLD  = 3
) (
  input  logic                     clk_a,
  input  logic                     arstn,
  input  logic                     flush,
  cdc_s2f_tx_sched_if.slave        s,
  output logic [DW-1:0]            data_out,
  output logic                     data_en,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     busy
);

  localparam int unsigned CW = (HOLD > 1) ? $clog2(HOLD) : 1;

  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] data_out_q, data_out_d;
  logic          data_en_q, data_en_d;

  logic          fifo_full, fifo_empty, fifo_pop, push;
  logic [DW-1:0] fifo_head;
  logic          can_launch, launch;

  assign s.s_ready = !fifo_full && !flush;
  assign push      = s.s_valid && s.s_ready;

  cdc_sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_a (clk_a),
    .arstn (arstn),
    .flush (flush),
    .push  (push),
    .wdata (s.s_data),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Flush wins over a launch on the same edge.
  assign can_launch = !fifo_empty && !flush;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_out_d = data_out_q;
    data_en_d  = 1'b0;
    launch     = 1'b0;
    unique case (state_q)
      StIdle: begin
        launch = can_launch;
      end
      StSend: begin
        cnt_d   = CW'(HOLD - 1);
        state_d = StGap;
      end
      StGap: begin
        if (cnt_q == '0) begin
          launch  = can_launch;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    if (launch) begin
      data_out_d = fifo_head;
      data_en_d  = 1'b1;
      state_d    = StSend;
    end
  end

  assign fifo_pop = launch;

  always_ff @(posedge clk_a or negedge arstn) begin
    if (!arstn) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      data_out_q <= '0;
      data_en_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      data_en_q  <= data_en_d;
    end
  end

  assign data_out = data_out_q;
  assign data_en  = data_en_q;
  assign busy     = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_cdc_s2f_tx_sched.sv
// Two launcher builds (HOLD=3 and HOLD=1) share one stimulus stream. Each has
// a timing model: a word queue plus the edge number of the last launch, where a
// launch happens whenever words are queued, no flush, and at least HOLD+1 edges
// have passed since the previous launch.
module tb_cdc_s2f_tx_sched;
  import cdc_pkg::*;

  localparam int DW    = 4;
  localparam int DEPTH = 4;

  logic          clk_a   = 1'b0;
  logic          arstn   = 1'b0;
  logic          flush   = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data  = '0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_a = ~clk_a;

  task automatic chk(input int hold, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL H%0d %s: got %0h expected %0h at %0t", hold, name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int HOLD = (g == 0) ? 3 : 1;

    cdc_s2f_tx_sched_if #(.DW(DW)) bus ();
    logic [DW-1:0]          data_out;
    logic                   data_en;
    logic [$clog2(DEPTH):0] fifo_level;
    logic                   busy;

    assign bus.s_valid = s_valid;
    assign bus.s_data  = s_data;

    cdc_s2f_tx_sched #(
      .DW    (DW),
      .DEPTH (DEPTH),
      .HOLD  (HOLD)
    ) dut (
      .clk_a      (clk_a),
      .arstn      (arstn),
      .flush      (flush),
      .s          (bus),
      .data_out   (data_out),
      .data_en    (data_en),
      .fifo_level (fifo_level),
      .busy       (busy)
    );

    logic [DW-1:0] mq[$];
    logic [DW-1:0] exp_q[$];
    int            edge_n = 0;
    int            last_l = -100;
    logic          m_en   = 1'b0;
    logic [DW-1:0] m_dout = '0;
    bit            acc, lau;

    initial forever begin
      @(posedge clk_a or negedge arstn);
      if (!arstn) begin
        mq.delete();
        exp_q.delete();
        edge_n = 0;
        last_l = -100;
        m_en   = 1'b0;
        m_dout = '0;
      end else begin
        edge_n++;
        acc  = s_valid && !flush && (mq.size() < DEPTH);
        lau  = (mq.size() != 0) && !flush && (edge_n - last_l >= HOLD + 1);
        m_en = lau;
        if (lau) begin
          m_dout = mq.pop_front();
          last_l = edge_n;
          exp_q.push_back(m_dout);
        end
        if (flush) mq.delete();
        else if (acc) mq.push_back(s_data);
      end
    end

    initial forever begin
      @(negedge clk_a);
      chk(HOLD, "data_en", 32'(data_en), 32'(m_en));
      if (data_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL H%0d launch_order: got pulse with %0h expected no pulse at %0t",
                   HOLD, data_out, $time);
        end else begin
          chk(HOLD, "launch_word", 32'(data_out), 32'(exp_q.pop_front()));
        end
      end
      chk(HOLD, "data_out", 32'(data_out), 32'(m_dout));
      chk(HOLD, "fifo_level", 32'(fifo_level), 32'(mq.size()));
      chk(HOLD, "s_ready", 32'(bus.s_ready), 32'((mq.size() < DEPTH) && !flush));
      chk(HOLD, "busy", 32'(busy), 32'((mq.size() != 0) || (edge_n - last_l <= HOLD)));
    end
  end

  task automatic step();
    @(posedge clk_a);
    #1;
  endtask

  // Assert reset mid-cycle, release it mid-way through the next cycle.
  task automatic pulse_reset();
    #2 arstn = 1'b0;
    #10 arstn = 1'b1;
    @(posedge clk_a);
    #1;
  endtask

  initial begin
    int pv;
    repeat (2) @(posedge clk_a);
    #3 arstn = 1'b1;

    // Single word into an idle block.
    step();
    s_valid = 1'b1;
    s_data  = 4'hA;
    step();
    s_valid = 1'b0;
    repeat (8) step();

    // Continuous supply: FIFO fills, s_ready drops, pulses back-to-back.
    for (int i = 0; i < 30; i++) begin
      s_valid = 1'b1;
      s_data  = DW'(i + 1);
      step();
    end
    s_valid = 1'b0;
    repeat (20) step();

    // Three words queued, flush mid-gap with a coincident (ignored) push.
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = DW'(4'h7 + i);
      step();
    end
    s_valid = 1'b0;
    repeat (2) step();
    flush   = 1'b1;
    s_valid = 1'b1;
    s_data  = 4'hE;
    step();
    flush   = 1'b0;
    s_valid = 1'b0;
    repeat (8) step();

    // Reset during a gap with words queued, then a fresh single push.
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = DW'(4'h3 + i);
      step();
    end
    s_valid = 1'b0;
    step();
    pulse_reset();
    s_valid = 1'b1;
    s_data  = 4'h5;
    step();
    s_valid = 1'b0;
    repeat (8) step();

    // Random traffic with varying offered load, occasional flush and reset.
    for (int blk = 0; blk < 8; blk++) begin
      pv = $urandom_range(10, 100);
      for (int i = 0; i < 50; i++) begin
        s_valid = ($urandom_range(0, 99) < pv);
        s_data  = DW'($urandom);
        flush   = ($urandom_range(0, 99) < 3);
        if ($urandom_range(0, 199) == 0) pulse_reset();
        else step();
      end
    end
    s_valid = 1'b0;
    flush   = 1'b0;
    repeat (30) step();

    chk(3, "drained", 32'(g_cfg[0].exp_q.size()), 32'd0);
    chk(1, "drained", 32'(g_cfg[1].exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cdc_s2f_tx_sched.md
Name: cdc_s2f_tx_sched

Overview:
- Source-side (clk_a, slow domain) launcher feeding the multibit slow-to-fast CDC stage.
- Accepts a valid/ready stream of DW-bit words and buffers them in a small FIFO.
- Presents each word on data_out with a one-cycle data_en pulse, then holds data_out stable and data_en low for HOLD clk_a cycles.
- This guarantees the clk_b two-flop enable synchroniser samples a static bus.

Parameters:
- DW, 4, data word width; must match the CDC stage's data_in width.
- DEPTH, 4, FIFO depth in words; power of two, at least 2.
- HOLD, 3, number of clk_a cycles data_en stays low after each pulse, with data_out frozen; at least 1.

Ports:
- clk_a  in  1  slow source clock.
- arstn  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous FIFO clear, active-high.
- s_valid  in  1  upstream word valid.
- s_data  in  DW  upstream word.
- s_ready  out  1  FIFO can accept a word.
- data_out  out  DW  registered word to CDC stage (its data_in).
- data_en  out  1  registered one-cycle launch strobe (CDC stage data_en).
- fifo_level  out  $clog2(DEPTH)+1  words currently queued (in-flight word excluded).
- busy  out  1  state!=IDLE or FIFO non-empty.

Behaviour:
- Reset (arstn low, async): data_out=0, data_en=0, FIFO pointers and level=0, state=IDLE, hold counter=0.
  - busy=0 and s_ready=1 from reset.
- FIFO push: on an edge with s_valid && s_ready.
  - s_ready = !full && !flush (combinational from registered state).
  - No bypass: a word is never launched in the cycle it is written.
- FIFO pop: only on a launch edge. Push and pop on the same edge leave the level unchanged. Pointers wrap modulo DEPTH.
- fifo_level ranges 0..DEPTH. Full means level==DEPTH.
- State machine (registered):
  - IDLE: if FIFO non-empty, the edge launches: pop head, data_out<=head, data_en<=1, go SEND. Otherwise stay in IDLE.
  - SEND (1 cycle, data_en high): data_en<=0, cnt<=HOLD-1, go GAP.
  - GAP (HOLD cycles, data_en low, data_out frozen): decrement cnt. When cnt==0:
    - if FIFO non-empty, launch on this edge and go SEND (back-to-back);
    - else go IDLE.
- Timing:
  - data_out changes only on launch edges.
  - Consecutive data_en pulses are exactly HOLD+1 cycles apart under continuous supply.
- Latency:
  - Word pushed at edge k into an empty, idle block: launched at edge k+1.
  - data_en is high in the cycle after edge k+1.
- Ordering: strict FIFO. No loss, no duplication, and nothing is dropped while s_ready is honoured.
- Flush:
  - Clears FIFO pointers and level on the edge it is sampled.
  - Pushes presented in that cycle are ignored.
  - An in-flight word (SEND/GAP) completes its full hold unchanged; data_out is never corrupted by flush.
  - After the hold, the state goes to IDLE.
- Flush in IDLE with a non-empty FIFO: flush wins and no launch occurs.
- Reset mid-operation: immediate return to reset values. Queued words are discarded and there is no partial pulse.
- System constraint: (HOLD+1)·T_clk_a ≥ T_clk_a + 3·T_clk_b, checked by integration. The block does not check it.

Decomposition:
- Shared package cdc_pkg holds:
  - state encoding typedef (IDLE, SEND, GAP);
  - localparam for the default CDC word width, 4.
- Natural sub-module: cdc_sync_fifo, a parameterised DW×DEPTH synchronous FIFO with push, pop, flush, full, empty and level.
- The scheduler FSM, hold counter and output registers live in cdc_s2f_tx_sched.

Test Plan (DW=4, DEPTH=4, HOLD=3 unless stated):
- Single push 0xA at edge 10 into idle block -> data_en=1 only in cycle after edge 11; data_out=0xA from edge 11 until next launch; busy returns to 0 after edge 15.
- Six words 1..6 offered continuously -> data_en pulses exactly 4 cycles apart; data_out sequence 1,2,3,4,5,6; s_ready low whenever fifo_level==4; no word lost or repeated.
- Level 3, push coincident with GAP-exit launch -> fifo_level stays 3; next launched word is the oldest queued.
- Three words queued, flush asserted one cycle mid-GAP -> data_out unchanged through the remaining hold; fifo_level=0 after the flush edge; no further data_en; IDLE after the hold.
- arstn pulsed low during GAP with 2 queued -> data_out=0, data_en=0, fifo_level=0 asynchronously; after release, a push at edge k gives data_en in the cycle after edge k+1.
- HOLD=1 build, continuous supply -> data_en pulses every 2 cycles; data_out stable across each pulse-plus-gap pair.
